segre_mem_responder: RTL and testbench

SEGRE_MEM_RESPONDER -- requirements
Module: segre_mem_responder

---
 rtl/segre_mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_segre_mem_responder.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_mem_responder.sv
// ---------------------------------------------------------------------------
// segre_mem_responder
//
// Line-granular memory model with a fixed response latency. It serves one
// request at a time. A request is taken in IDLE. The responder then waits
// LATENCY-1 cycles in WAIT and presents the response in RESP until the
// requester consumes it.
//
// Parameters
//   ADDR_WIDTH   byte address width
//   LINE_WIDTH   line width in bits (offset OFF = log2(LINE_WIDTH/8))
//   DEPTH_LINES  number of stored lines, power of two (IDX_W = log2)
//   LATENCY      cycles from acceptance to response, >= 1
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-high reset
//   req_valid_i  request present
//   req_ready_o  responder can accept a request (IDLE and not in reset)
//   req_we_i     1 = line write, 0 = line read
//   req_addr_i   byte address; offset bits and bits above the index ignored
//   req_wdata_i  write line data
//   req_id_i     requester tag (0 = icache, 1 = dcache)
//   rsp_valid_o  response present
//   rsp_ready_i  requester consumes the response
//   rsp_rdata_o  read line data, zero for write acknowledges
//   rsp_id_o     tag of the request being answered
//   rsp_we_o     1 = write acknowledge, 0 = read data
// ---------------------------------------------------------------------------
module segre_mem_responder #(
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_WIDTH  = 128,
    parameter int DEPTH_LINES = 1024,
    parameter int LATENCY     = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LINE_WIDTH-1:0] req_wdata_i,
    input  logic                  req_id_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [LINE_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_id_o,
    output logic                  rsp_we_o
);

    localparam int OFF   = $clog2(LINE_WIDTH / 8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_next;

    // Request captured at acceptance; later input changes are ignored.
    logic                 r_we;
    logic                 r_id;
    logic [IDX_W-1:0]     r_idx;
    logic [LINE_WIDTH-1:0] r_wdata;

    // Line storage, never reset. Read data is registered.
    logic [LINE_WIDTH-1:0] r_mem [DEPTH_LINES];
    logic [LINE_WIDTH-1:0] r_mem_rdata;

    logic                 w_accept;
    logic                 w_enter_resp;
    logic                 w_in_resp;
    logic [IDX_W-1:0]     w_req_idx;
    logic                 w_mem_we;
    logic [IDX_W-1:0]     w_mem_idx;
    logic [LINE_WIDTH-1:0] w_mem_wdata;
    logic                 w_unused_bits;

    assign w_req_idx   = req_addr_i[OFF+IDX_W-1:OFF];
    assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
    assign w_accept    = req_valid_i && req_ready_o;

    // Offset bits and bits above the index have no function (aliasing).
    assign w_unused_bits = ^{req_addr_i, r_wdata, r_idx};

    // ---------------------------------------------------------------------
    // Next-state / counter logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_next   = CNT_W'(LATENCY - 1);
                    w_state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The memory access happens on the edge that enters RESP.
    assign w_enter_resp = (r_state != ST_RESP) && (w_state_next == ST_RESP);

    // ---------------------------------------------------------------------
    // Control / request registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_id    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we_i;
                r_id    <= req_id_i;
                r_idx   <= w_req_idx;
                r_wdata <= req_wdata_i;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Memory port source. With LATENCY = 1 the acceptance edge is also the
    // RESP entry edge, so the request fields have not been registered yet
    // and the port is fed straight from the inputs.
    // ---------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_mem_we    = req_we_i;
            assign w_mem_idx   = w_req_idx;
            assign w_mem_wdata = req_wdata_i;
        end else begin : g_registered
            assign w_mem_we    = r_we;
            assign w_mem_idx   = r_idx;
            assign w_mem_wdata = r_wdata;
        end
    endgenerate

    // Reset forces IDLE asynchronously, so no commit can happen while
    // rst_i is high or after a request is discarded in WAIT.
    always_ff @(posedge clk_i) begin
        if (w_enter_resp) begin
            if (w_mem_we) begin
                r_mem[w_mem_idx] <= w_mem_wdata;
            end else begin
                r_mem_rdata <= r_mem[w_mem_idx];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: zero outside RESP, held by the registers while in RESP.
    // ---------------------------------------------------------------------
    assign w_in_resp   = (r_state == ST_RESP);
    assign rsp_valid_o = w_in_resp;
    assign rsp_id_o    = w_in_resp & r_id;
    assign rsp_we_o    = w_in_resp & r_we;
    assign rsp_rdata_o = (w_in_resp && !r_we) ? r_mem_rdata : '0;

endmodule

// File: tb/tb_segre_mem_responder.sv
module tb_segre_mem_responder;

    localparam int LAT_A = 5;

    logic clk;
    logic rst;

    // Instance A: default parameters (LATENCY = 5)
    logic         a_req_valid, a_req_ready, a_we, a_id;
    logic [31:0]  a_addr;
    logic [127:0] a_wdata, a_rsp_rdata;
    logic         a_rsp_valid, a_rsp_ready, a_rsp_id, a_rsp_we;

    // Instance B: LATENCY = 1
    logic         b_req_valid, b_req_ready, b_we, b_id;
    logic [31:0]  b_addr;
    logic [127:0] b_wdata, b_rsp_rdata;
    logic         b_rsp_valid, b_rsp_ready, b_rsp_id, b_rsp_we;

    segre_mem_responder #(.LATENCY(LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
        .req_we_i(a_we), .req_addr_i(a_addr), .req_wdata_i(a_wdata), .req_id_i(a_id),
        .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
        .rsp_rdata_o(a_rsp_rdata), .rsp_id_o(a_rsp_id), .rsp_we_o(a_rsp_we)
    );

    segre_mem_responder #(.LATENCY(1)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
        .req_we_i(b_we), .req_addr_i(b_addr), .req_wdata_i(b_wdata), .req_id_i(b_id),
        .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
        .rsp_rdata_o(b_rsp_rdata), .rsp_id_o(b_rsp_id), .rsp_we_o(b_rsp_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic         id;
        logic [127:0] exp;
        int           hold;
    } vec_t;

    typedef struct {
        logic         we;
        logic         id;
        logic [127:0] rdata;
    } rsp_t;

    rsp_t sb[$];
    vec_t vecs[11];

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D1 = 128'hDEADBEEFCAFEF00D123456789ABCDEF0;
    localparam logic [127:0] D2 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] D3 = 128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C;
    localparam logic [127:0] D4 = 128'h13579BDF2468ACE013579BDF2468ACE0;
    localparam logic [127:0] DA = {16{8'hAA}};
    localparam logic [127:0] D5 = {16{8'h55}};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic we, input logic id, input logic [127:0] rd);
        rsp_t e;
        e.we    = we;
        e.id    = id;
        e.rdata = we ? 128'h0 : rd;
        sb.push_back(e);
    endtask

    // One full transaction on instance A with optional response backpressure.
    task automatic txn_a(input string name, input logic we, input logic [31:0] addr,
                         input logic [127:0] wd, input logic id,
                         input logic [127:0] exp, input int hold);
        int   j;
        logic ready_seen;
        rsp_t e;
        @(negedge clk);
        chk({name, ".ready_idle"}, a_req_ready, 1);
        a_req_valid = 1'b1;
        a_we        = we;
        a_addr      = addr;
        a_wdata     = wd;
        a_id        = id;
        a_rsp_ready = (hold == 0);
        push_exp(we, id, exp);
        @(posedge clk);
        #1;
        // Input changes after acceptance must not affect the response.
        a_req_valid = 1'b0;
        a_we        = ~we;
        a_addr      = ~addr;
        a_wdata     = ~wd;
        a_id        = ~id;
        j          = 0;
        ready_seen = 1'b0;
        @(negedge clk);
        while (!a_rsp_valid && j < 20) begin
            if (a_req_ready) ready_seen = 1'b1;
            j++;
            @(negedge clk);
        end
        chk({name, ".latency"}, 128'(j), 128'(LAT_A - 1));
        chk({name, ".ready_in_wait"}, ready_seen, 0);
        e = sb.pop_front();
        chk({name, ".rdata"}, a_rsp_rdata, e.rdata);
        chk({name, ".id"}, a_rsp_id, e.id);
        chk({name, ".we"}, a_rsp_we, e.we);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, ".hold_valid"}, a_rsp_valid, 1);
            chk({name, ".hold_rdata"}, a_rsp_rdata, e.rdata);
            chk({name, ".hold_id_we"}, {a_rsp_id, a_rsp_we}, {e.id, e.we});
            chk({name, ".hold_ready"}, a_req_ready, 0);
        end
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({name, ".valid_after"}, a_rsp_valid, 0);
        chk({name, ".ready_after"}, a_req_ready, 1);
        chk({name, ".rdata_after"}, a_rsp_rdata, 0);
        $display("txn %s we=%0d addr=%h id=%0d rdata=%h", name, we, addr, id, e.rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, D0, 1'b1, 128'h0, 0};
        vecs[1]  = '{1'b0, 32'h0000_0040, D5, 1'b0, D0,     0};
        vecs[2]  = '{1'b1, 32'h0000_004C, D1, 1'b0, 128'h0, 0};
        vecs[3]  = '{1'b0, 32'h0000_0040, D5, 1'b1, D1,     0};
        vecs[4]  = '{1'b0, 32'h0000_4040, D5, 1'b0, D1,     0};
        vecs[5]  = '{1'b1, 32'h0000_0080, DA, 1'b1, 128'h0, 0};
        vecs[6]  = '{1'b0, 32'h0000_0080, D5, 1'b1, DA,     0};
        vecs[7]  = '{1'b1, 32'h0000_FFF0, D2, 1'b0, 128'h0, 0};
        vecs[8]  = '{1'b0, 32'h0000_3FF0, D5, 1'b1, D2,     0};
        vecs[9]  = '{1'b0, 32'hFFFF_C04F, D5, 1'b0, D1,     0};
        vecs[10] = '{1'b0, 32'h0000_0040, D5, 1'b1, D1,     3};

        rst = 1'b1;
        {a_req_valid, a_we, a_id, a_rsp_ready} = '0;
        {b_req_valid, b_we, b_id, b_rsp_ready} = '0;
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;

        // Reset state
        @(posedge clk);
        #1;
        chk("rst.ready", a_req_ready, 0);
        chk("rst.valid", a_rsp_valid, 0);
        chk("rst.outs", {a_rsp_rdata, a_rsp_id, a_rsp_we}, 0);
        chk("rst.b_ready", b_req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst.ready_release", a_req_ready, 1);

        for (int i = 0; i < 11; i++) begin
            txn_a($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].id, vecs[i].exp, vecs[i].hold);
        end

        // Reset while a write to 0x80 is in WAIT: nothing committed.
        @(negedge clk);
        a_req_valid = 1'b1; a_we = 1'b1; a_addr = 32'h80; a_wdata = D5; a_id = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstwait.valid", a_rsp_valid, 0);
        chk("rstwait.ready", a_req_ready, 0);
        chk("rstwait.outs", {a_rsp_rdata, a_rsp_id, a_rsp_we}, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwait.ready_release", a_req_ready, 1);
        $display("txn rstwait we=1 addr=00000080 discarded");
        txn_a("rstwait_read", 1'b0, 32'h80, D0, 1'b0, DA, 0);

        // Reset while a write to 0x90 sits in RESP: commit survives.
        @(negedge clk);
        a_req_valid = 1'b1; a_we = 1'b1; a_addr = 32'h90; a_wdata = D4; a_id = 1'b0;
        a_rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        repeat (LAT_A - 1) @(posedge clk);
        #1;
        chk("rstresp.valid_before", a_rsp_valid, 1);
        chk("rstresp.we_before", a_rsp_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstresp.valid", a_rsp_valid, 0);
        chk("rstresp.we", a_rsp_we, 0);
        @(negedge clk);
        rst = 1'b0;
        a_rsp_ready = 1'b1;
        $display("txn rstresp we=1 addr=00000090 dropped");
        txn_a("rstresp_read", 1'b0, 32'h90, D0, 1'b1, D4, 0);

        // LATENCY = 1, back-to-back requests every two cycles.
        b_rsp_ready = 1'b1;
        @(negedge clk);
        chk("b.valid_idle", b_rsp_valid, 0);
        b_req_valid = 1'b1; b_we = 1'b1; b_addr = 32'h10; b_wdata = D3; b_id = 1'b1;
        push_exp(1'b1, 1'b1, 128'h0);
        @(posedge clk);
        #1;
        b_we = 1'b0; b_addr = 32'h10; b_wdata = D0; b_id = 1'b0;
        push_exp(1'b0, 1'b0, D3);
        @(negedge clk);
        begin
            rsp_t e;
            e = sb.pop_front();
            chk("b.w.valid", b_rsp_valid, 1);
            chk("b.w.rdata", b_rsp_rdata, e.rdata);
            chk("b.w.id_we", {b_rsp_id, b_rsp_we}, {e.id, e.we});
            chk("b.w.ready_busy", b_req_ready, 0);
            $display("txn b.write we=1 addr=00000010 id=1");
        end
        @(negedge clk);
        chk("b.gap.valid", b_rsp_valid, 0);
        chk("b.gap.ready", b_req_ready, 1);
        @(posedge clk);
        #1;
        b_req_valid = 1'b0;
        b_wdata = D5;
        @(negedge clk);
        begin
            rsp_t e;
            e = sb.pop_front();
            chk("b.r.valid", b_rsp_valid, 1);
            chk("b.r.rdata", b_rsp_rdata, e.rdata);
            chk("b.r.id_we", {b_rsp_id, b_rsp_we}, {e.id, e.we});
            $display("txn b.read we=0 addr=00000010 id=0 rdata=%h", e.rdata);
        end
        @(negedge clk);
        chk("b.end.valid", b_rsp_valid, 0);
        chk("b.end.ready", b_req_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
